// File: rtl/uart_rx_frame_assembler.sv
// uart_rx_frame_assembler
// Hunts for SYNC_BYTE in the uart_rx byte stream, validates LEN/CHK framing and
// packs the payload little-endian into WORD_WIDTH words on a valid/ready stream.
// Each frame ends with a one-cycle frame_done pulse, flagged by frame_error on abort.
module uart_rx_frame_assembler #(
   parameter int         WORD_WIDTH     = 32,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CLOCKS = 100_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic [WORD_WIDTH-1:0] out_word,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic [1:0]            error_code
);

   localparam int BPW = WORD_WIDTH / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IW-1:0] IDX_MAX  = IW'(BPW - 1);
   localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CLOCKS - 1);

   localparam logic [1:0] ERR_CHK     = 2'd0;
   localparam logic [1:0] ERR_ZLEN    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   typedef enum logic [2:0] {IDLE, LENGTH, PAYLOAD, CHECKSUM, FLUSH} state_t;

   state_t                state, state_nxt;
   logic [7:0]            remaining;
   logic [IW-1:0]         idx;
   logic [7:0]            chk;
   logic [31:0]           timer;
   logic [WORD_WIDTH-1:0] word_buf;
   logic [WORD_WIDTH-1:0] word_ins;

   // FSM control strobes
   logic       len_ld, byte_acc, word_push, buf_clr, final_ld;
   logic       err_set, ok_done, timer_clr, timer_inc;
   logic [1:0] err_val;

   logic slot_free;
   logic timed_out;

   assign slot_free = !out_valid || out_ready;
   assign timed_out = (timer == TMO_LAST);

   // Word buffer with the incoming byte dropped into lane idx
   always_comb begin
      word_ins = word_buf;
      for (int k = 0; k < BPW; k++)
         if (idx == IW'(k)) word_ins[8*k +: 8] = in_data;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_nxt = state;
      len_ld    = 1'b0;
      byte_acc  = 1'b0;
      word_push = 1'b0;
      buf_clr   = 1'b0;
      final_ld  = 1'b0;
      err_set   = 1'b0;
      err_val   = ERR_CHK;
      ok_done   = 1'b0;
      timer_clr = 1'b0;
      timer_inc = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_data == SYNC_BYTE) begin
               timer_clr = 1'b1;
               state_nxt = LENGTH;
            end
         end
         LENGTH: begin
            if (in_valid) begin
               timer_clr = 1'b1;
               if (in_data == 8'd0) begin
                  err_set   = 1'b1;
                  err_val   = ERR_ZLEN;
                  state_nxt = IDLE;
               end else begin
                  len_ld    = 1'b1;
                  state_nxt = PAYLOAD;
               end
            end else if (timed_out) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         PAYLOAD: begin
            if (in_valid) begin
               timer_clr = 1'b1;
               if (remaining == 8'd1) begin
                  // last byte: keep the (possibly partial) word for FLUSH
                  byte_acc  = 1'b1;
                  state_nxt = CHECKSUM;
               end else if (idx == IDX_MAX) begin
                  if (slot_free) begin
                     byte_acc  = 1'b1;
                     word_push = 1'b1;
                  end else begin
                     // pending word is left untouched; frame is abandoned
                     err_set   = 1'b1;
                     err_val   = ERR_OVERRUN;
                     state_nxt = IDLE;
                  end
               end else begin
                  byte_acc = 1'b1;
               end
            end else if (timed_out) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         CHECKSUM: begin
            if (in_valid) begin
               timer_clr = 1'b1;
               if (in_data == chk) begin
                  state_nxt = FLUSH;
               end else begin
                  err_set   = 1'b1;
                  err_val   = ERR_CHK;
                  buf_clr   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (timed_out) begin
               err_set   = 1'b1;
               err_val   = ERR_TIMEOUT;
               state_nxt = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         FLUSH: begin
            // bytes arriving here are dropped on purpose
            if (slot_free) begin
               final_ld  = 1'b1;
               ok_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: counters, checksum, word buffer, output slot and status
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining   <= '0;
         idx         <= '0;
         chk         <= '0;
         timer       <= '0;
         word_buf    <= '0;
         out_word    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         error_code  <= '0;
      end else begin
         frame_done  <= 1'b0;
         frame_error <= 1'b0;

         if (timer_clr)      timer <= '0;
         else if (timer_inc) timer <= timer + 32'd1;

         if (len_ld) begin
            remaining <= in_data;
            chk       <= in_data;
            idx       <= '0;
            word_buf  <= '0;
         end else if (byte_acc) begin
            remaining <= remaining - 8'd1;
            chk       <= chk ^ in_data;
            idx       <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            word_buf  <= word_push ? '0 : word_ins;
         end else if (buf_clr || final_ld) begin
            word_buf  <= '0;
         end

         if (word_push) begin
            out_word  <= word_ins;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
         end else if (final_ld) begin
            out_word  <= word_buf;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         if (err_set) begin
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            error_code  <= err_val;
         end else if (ok_done) begin
            frame_done  <= 1'b1;
            error_code  <= ERR_CHK;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for uart_rx_frame_assembler: good/bad frames, hunt, zero LEN,
// timeout, overrun with backpressure and mid-frame reset.
module tb_uart_rx_frame_assembler;

   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [31:0] out_word;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        frame_done;
   logic        frame_error;
   logic [1:0]  error_code;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  tx[$];
   logic [32:0] w_q[$];   // {last, word} per accepted word
   logic [2:0]  d_q[$];   // {error, code} per frame_done

   uart_rx_frame_assembler #(
      .WORD_WIDTH(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CLOCKS(TMO)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .frame_done(frame_done), .frame_error(frame_error),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   // Record handshakes and frame completions mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) w_q.push_back({out_last, out_word});
         if (frame_done) d_q.push_back({frame_error, error_code});
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_tx();
      foreach (tx[i]) begin
         in_data  = tx[i];
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // Compare and clear the recorded words/completions of one frame
   task automatic expect_frame(input string tag, input int nw, input logic [32:0] w0,
                               input logic [32:0] w1, input logic [2:0] d);
      check({tag, ".nwords"}, w_q.size(), nw);
      if (nw > 0) check({tag, ".w0"}, (w_q.size() > 0) ? w_q[0] : 33'h0, w0);
      if (nw > 1) check({tag, ".w1"}, (w_q.size() > 1) ? w_q[1] : 33'h0, w1);
      check({tag, ".ndone"}, d_q.size(), 1);
      check({tag, ".status"}, (d_q.size() > 0) ? d_q[0] : 3'b111, d);
      w_q.delete();
      d_q.delete();
   endtask

   task automatic good_a(input string tag);
      tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_tx();
      idle(4);
      expect_frame(tag, 1, {1'b1, 32'h00332211}, 33'h0, 3'b000);
   endtask

   initial begin
      rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
      idle(3);
      check("rst.valid", out_valid, 0);
      check("rst.word", out_word, 0);
      check("rst.last", out_last, 0);
      check("rst.done", frame_done, 0);
      check("rst.err", frame_error, 0);
      check("rst.code", error_code, 0);
      rst = 1'b0;
      idle(2);

      // Good partial frame with final-word latency
      tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_tx();
      check("A.lat1.valid", out_valid, 0);
      idle(1);
      check("A.lat2.valid", out_valid, 1);
      check("A.lat2.last", out_last, 1);
      check("A.lat2.done", frame_done, 1);
      check("A.lat2.err", frame_error, 0);
      idle(3);
      expect_frame("A", 1, {1'b1, 32'h00332211}, 33'h0, 3'b000);

      // Two-word frame, intermediate word one cycle after its last byte
      tx = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
      send_tx();
      check("B.mid.valid", out_valid, 1);
      check("B.mid.word", out_word, 32'h04030201);
      check("B.mid.last", out_last, 0);
      tx = '{8'h05, 8'h04};
      send_tx();
      idle(4);
      expect_frame("B", 2, {1'b0, 32'h04030201}, {1'b1, 32'h00000005}, 3'b000);

      // Bad checksum, then recovery
      tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      send_tx();
      idle(4);
      expect_frame("C", 0, 33'h0, 33'h0, 3'b100);
      good_a("C.rec");

      // Hunt through garbage, zero LEN, then recovery
      tx = '{8'h00, 8'hFF, 8'hA5, 8'h00};
      send_tx();
      idle(3);
      expect_frame("D", 0, 33'h0, 33'h0, 3'b101);
      good_a("D.rec");

      // Timeout boundary: nothing before TIMEOUT_CLOCKS idle cycles, error after
      tx = '{8'hA5, 8'h03, 8'h11};
      send_tx();
      idle(TMO - 1);
      check("E.early", d_q.size(), 0);
      idle(4);
      expect_frame("E", 0, 33'h0, 33'h0, 3'b110);
      good_a("E.rec");

      // Overrun with consumer stalled: first word must stay put
      out_ready = 1'b0;
      tx = '{8'hA5, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04};
      send_tx();
      for (int b = 5; b <= 9; b++) begin
         tx = '{8'(b)};
         send_tx();
         check($sformatf("F.hold%0d.valid", b), out_valid, 1);
         check($sformatf("F.hold%0d.word", b), out_word, 32'h04030201);
      end
      tx = '{8'h08};
      send_tx();
      idle(2);
      check("F.held.last", out_last, 0);
      out_ready = 1'b1;
      idle(2);
      expect_frame("F", 1, {1'b0, 32'h04030201}, 33'h0, 3'b111);
      check("F.drained", out_valid, 0);

      // Reset mid-frame with a pending word
      out_ready = 1'b0;
      tx = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
      send_tx();
      check("R.pre.valid", out_valid, 1);
      rst = 1'b1;
      idle(1);
      check("R.valid", out_valid, 0);
      check("R.word", out_word, 0);
      check("R.done", frame_done, 0);
      check("R.code", error_code, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      idle(3);
      check("R.nodone", d_q.size(), 0);
      w_q.delete();
      good_a("R.rec");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
